// File: rtl/mag_cmp_pkg.sv
// Shared types and elaboration-time helpers for the pipelined magnitude comparator.
// Optional equality output is enabled in the top level by MAG_CMP_PIPE_EQU_EN.
package mag_cmp_pkg;

  // Widest group a single merge may reduce; SPLIT must not exceed this.
  localparam int MAX_SPLIT = 16;

  typedef struct packed {
    logic grt;
    logic lst;
  } cmp_t;

  function automatic int pow_int(input int base, input int exp);
    int r;
    r = 1;
    for (int i = 0; i < exp; i++) r = r * base;
    return r;
  endfunction

  function automatic int calc_levels(input int width, input int split);
    int lv;
    int span;
    lv   = 0;
    span = 1;
    while (span < width) begin
      span = span * split;
      lv++;
    end
    return (lv < 1) ? 1 : lv;
  endfunction

  // Number of (g,l) pairs in tree levels 0..k-1, leaf level included.
  function automatic int lvl_off(input int split, input int levels, input int k);
    int off;
    off = 0;
    for (int j = 0; j < k; j++) off = off + pow_int(split, levels - j);
    return off;
  endfunction

  // Highest-indexed group holding a decision wins; no decision merges to equal.
  function automatic cmp_t cmp_merge(input cmp_t [MAX_SPLIT-1:0] grp, input int n);
    cmp_t res;
    res = '0;
    for (int i = MAX_SPLIT - 1; i >= 0; i--) begin
      if (i < n && !(res.grt || res.lst)) res = grp[i];
    end
    return res;
  endfunction

endpackage

// File: rtl/mag_cmp_stage.sv
// One reduction-tree level of the magnitude comparator: merges SPLIT pairs per
// output group and registers the result together with valid and tag.
module mag_cmp_stage
  import mag_cmp_pkg::*;
#(
  parameter int SPLIT = 2,
  parameter int N_OUT = 1,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     up_vld,
  output logic                     up_rdy,
  input  cmp_t [SPLIT*N_OUT-1:0]   up_cmp,
  input  logic [TAG_W-1:0]         up_tag,
  output logic                     vld,
  input  logic                     dn_rdy,
  output cmp_t [N_OUT-1:0]         cmp,
  output logic [TAG_W-1:0]         tag
);

  cmp_t [MAX_SPLIT-1:0] grp;
  cmp_t [N_OUT-1:0]     merged;

  assign up_rdy = ~vld | dn_rdy;

  always_comb begin
    grp    = '0;
    merged = '0;
    for (int j = 0; j < N_OUT; j++) begin
      grp = '0;
      for (int i = 0; i < SPLIT; i++) grp[i] = up_cmp[j*SPLIT + i];
      merged[j] = cmp_merge(grp, SPLIT);
    end
  end

  // Data only moves with a real transaction so the stage holds its last result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= 1'b0;
      cmp <= '0;
      tag <= '0;
    end else if (up_rdy) begin
      vld <= up_vld;
      if (up_vld) begin
        cmp <= merged;
        tag <= up_tag;
      end
    end
  end

endmodule

// File: rtl/mag_cmp_pipe.sv
// Pipelined SPLIT-ary magnitude comparator with valid/ready flow control.
// Define MAG_CMP_PIPE_EQU_EN to add the registered out_equ port.
module mag_cmp_pipe
  import mag_cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SPLIT = 2,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic             in_sgn,
  input  logic [WIDTH-1:0] in_val,
  input  logic [WIDTH-1:0] in_rfr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             out_grt,
  output logic             out_lst,
  output logic [TAG_W-1:0] out_tag
`ifdef MAG_CMP_PIPE_EQU_EN
  ,
  output logic             out_equ
`endif
);

  localparam int LEVELS = calc_levels(WIDTH, SPLIT);
  localparam int NPAD   = pow_int(SPLIT, LEVELS);
  localparam int TOTAL  = lvl_off(SPLIT, LEVELS, LEVELS + 1) - NPAD;

  logic [WIDTH-1:0] sgn_mask;
  logic [NPAD-1:0]  val_pad;
  logic [NPAD-1:0]  rfr_pad;
  cmp_t [NPAD-1:0]  leaf;

  wire cmp_t [TOTAL-1:0]      lvl;
  wire [LEVELS:0]             vld;
  wire [LEVELS+1:1]           rdy;
  wire [LEVELS:0][TAG_W-1:0]  tags;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  always_comb begin
    sgn_mask           = '0;
    sgn_mask[WIDTH-1]  = in_sgn;
    val_pad            = NPAD'(in_val ^ sgn_mask);
    rfr_pad            = NPAD'(in_rfr ^ sgn_mask);
    leaf               = '0;
    for (int i = 0; i < NPAD; i++) begin
      leaf[i].grt = val_pad[i] & ~rfr_pad[i];
      leaf[i].lst = ~val_pad[i] & rfr_pad[i];
    end
  end

  assign vld[0]         = in_vld;
  assign tags[0]        = in_tag;
  assign rdy[LEVELS+1]  = out_rdy;

`ifdef MAG_CMP_PIPE_EQU_EN
  wire cmp_t [SPLIT-1:0] last_in;
`endif

  for (genvar k = 1; k <= LEVELS; k++) begin : g_stage
    localparam int IN_N    = pow_int(SPLIT, LEVELS - k + 1);
    localparam int OUT_N   = pow_int(SPLIT, LEVELS - k);
    localparam int OUT_OFF = lvl_off(SPLIT, LEVELS, k) - NPAD;

    wire cmp_t [IN_N-1:0] stg_in;

    if (k == 1) begin : g_first
      assign stg_in = leaf;
    end else begin : g_inner
      localparam int IN_OFF = lvl_off(SPLIT, LEVELS, k - 1) - NPAD;
      assign stg_in = lvl[IN_OFF +: IN_N];
    end

`ifdef MAG_CMP_PIPE_EQU_EN
    if (k == LEVELS) begin : g_last
      assign last_in = stg_in;
    end
`endif

    mag_cmp_stage #(
      .SPLIT (SPLIT),
      .N_OUT (OUT_N),
      .TAG_W (TAG_W)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .up_vld (vld[k-1]),
      .up_rdy (rdy[k]),
      .up_cmp (stg_in),
      .up_tag (tags[k-1]),
      .vld    (vld[k]),
      .dn_rdy (rdy[k+1]),
      .cmp    (lvl[OUT_OFF +: OUT_N]),
      .tag    (tags[k])
    );
  end

  assign in_rdy  = rdy[1];
  assign out_vld = vld[LEVELS];
  assign out_grt = lvl[TOTAL-1].grt;
  assign out_lst = lvl[TOTAL-1].lst;
  assign out_tag = tags[LEVELS];

`ifdef MAG_CMP_PIPE_EQU_EN
  logic equ_q;

  // Equal means no pair in the final group reached a decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      equ_q <= 1'b0;
    end else if (rdy[LEVELS] && vld[LEVELS-1]) begin
      equ_q <= ~|last_in;
    end
  end

  assign out_equ = equ_q;
`endif

endmodule

// File: tb/tb_mag_cmp_pipe.sv
// Self-checking bench for mag_cmp_pipe (WIDTH=4, SPLIT=2): directed table,
// random streaming/backpressure against a scoreboard, and mid-stream reset.
`timescale 1ns/1ps
module tb_mag_cmp_pipe;

  localparam int WIDTH  = 4;
  localparam int SPLIT  = 2;
  localparam int TAG_W  = 4;
  localparam int LEVELS = 2;
  localparam int NVEC   = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_vld = 1'b0;
  logic             in_sgn = 1'b0;
  logic [WIDTH-1:0] in_val = '0;
  logic [WIDTH-1:0] in_rfr = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_rdy = 1'b1;
  logic             in_rdy;
  logic             out_vld;
  logic             out_grt;
  logic             out_lst;
  logic [TAG_W-1:0] out_tag;
`ifdef MAG_CMP_PIPE_EQU_EN
  logic             out_equ;
`endif

  typedef struct {
    logic             sgn;
    logic [WIDTH-1:0] val;
    logic [WIDTH-1:0] rfr;
    logic [TAG_W-1:0] tag;
    logic             grt;
    logic             lst;
  } vec_t;

  typedef struct {
    logic             grt;
    logic             lst;
    logic [TAG_W-1:0] tag;
  } exp_t;

  vec_t vecs [NVEC];
  exp_t expQ [$];

  int nChecks  = 0;
  int nFails   = 0;
  int popCount = 0;
  int cycleCnt = 0;
  int firstPop = -1;
  int lastPop  = -1;
  logic randDone = 1'b0;

  logic             stallPrev = 1'b0;
  logic             heldGrt;
  logic             heldLst;
  logic [TAG_W-1:0] heldTag;

  mag_cmp_pipe #(
    .WIDTH (WIDTH),
    .SPLIT (SPLIT),
    .TAG_W (TAG_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .in_sgn  (in_sgn),
    .in_val  (in_val),
    .in_rfr  (in_rfr),
    .in_tag  (in_tag),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .out_grt (out_grt),
    .out_lst (out_lst),
    .out_tag (out_tag)
`ifdef MAG_CMP_PIPE_EQU_EN
    ,
    .out_equ (out_equ)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: interpret operands as integers and compare arithmetically.
  function automatic logic [1:0] refCompare(input logic sgn, input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    int av;
    int bv;
    av = int'(a);
    bv = int'(b);
    if (sgn) begin
      if (av >= 8) av = av - 16;
      if (bv >= 8) bv = bv - 16;
    end
    return {av > bv, av < bv};
  endfunction

  // Scoreboard and stall-stability monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    logic [1:0] r;
    if (!rst_n) begin
      stallPrev = 1'b0;
    end else begin
      if (stallPrev) begin
        checkOutput("stall out_vld held", int'(out_vld), 1);
        checkOutput("stall out_grt held", int'(out_grt), int'(heldGrt));
        checkOutput("stall out_lst held", int'(out_lst), int'(heldLst));
        checkOutput("stall out_tag held", int'(out_tag), int'(heldTag));
      end
      stallPrev = out_vld & ~out_rdy;
      heldGrt   = out_grt;
      heldLst   = out_lst;
      heldTag   = out_tag;
      if (out_vld && out_rdy) begin
        checkOutput("sb result expected", int'(expQ.size() != 0), 1);
        if (expQ.size() != 0) begin
          e = expQ.pop_front();
          checkOutput("sb grt", int'(out_grt), int'(e.grt));
          checkOutput("sb lst", int'(out_lst), int'(e.lst));
          checkOutput("sb tag", int'(out_tag), int'(e.tag));
`ifdef MAG_CMP_PIPE_EQU_EN
          checkOutput("sb equ", int'(out_equ), int'(~e.grt & ~e.lst));
`endif
        end
        popCount++;
        if (firstPop < 0) firstPop = cycleCnt;
        lastPop = cycleCnt;
      end
      if (in_vld && in_rdy) begin
        r = refCompare(in_sgn, in_val, in_rfr);
        e.grt = r[1];
        e.lst = r[0];
        e.tag = in_tag;
        expQ.push_back(e);
      end
    end
  end

  task automatic sendTxn(input logic sgn, input logic [WIDTH-1:0] v,
                         input logic [WIDTH-1:0] r, input logic [TAG_W-1:0] t);
    int waitCyc;
    waitCyc = 0;
    in_vld  = 1'b1;
    in_sgn  = sgn;
    in_val  = v;
    in_rfr  = r;
    in_tag  = t;
    @(negedge clk);
    while (!in_rdy && waitCyc < 200) begin
      @(negedge clk);
      waitCyc++;
    end
    if (!in_rdy) checkOutput("accept within bound", int'(in_rdy), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    sendTxn(v.sgn, v.val, v.rfr, v.tag);
    in_vld = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expQ.size() != 0 || out_vld) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain queue empty", expQ.size(), 0);
    checkOutput("drain out_vld low", int'(out_vld), 0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 4'hA, 4'h5, 4'd3,  1'b1, 1'b0};
    vecs[1] = '{1'b0, 4'h7, 4'h7, 4'd5,  1'b0, 1'b0};
    vecs[2] = '{1'b1, 4'hA, 4'h5, 4'd6,  1'b0, 1'b1};
    vecs[3] = '{1'b1, 4'h8, 4'hF, 4'd7,  1'b0, 1'b1};
    vecs[4] = '{1'b0, 4'h8, 4'hF, 4'd8,  1'b0, 1'b1};
    vecs[5] = '{1'b1, 4'h7, 4'h8, 4'd9,  1'b1, 1'b0};
    vecs[6] = '{1'b0, 4'h0, 4'hF, 4'd10, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 4'hF, 4'hF, 4'd11, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 4'hF, 4'h0, 4'd12, 1'b1, 1'b0};
    vecs[9] = '{1'b1, 4'h0, 4'hF, 4'd13, 1'b1, 1'b0};

    // Reset behaviour.
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset out_vld", int'(out_vld), 0);
    checkOutput("reset out_grt", int'(out_grt), 0);
    checkOutput("reset out_lst", int'(out_lst), 0);
    checkOutput("reset out_tag", int'(out_tag), 0);
    checkOutput("reset in_rdy", int'(in_rdy), 1);
`ifdef MAG_CMP_PIPE_EQU_EN
    checkOutput("reset out_equ", int'(out_equ), 0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idle out_vld", int'(out_vld), 0);
    checkOutput("idle out_grt", int'(out_grt), 0);
    checkOutput("idle out_lst", int'(out_lst), 0);
    checkOutput("idle in_rdy", int'(in_rdy), 1);

    // Directed table with exact latency check.
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d early out_vld", i), int'(out_vld), 0);
      repeat (LEVELS - 1) @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d out_vld", i), int'(out_vld), 1);
      checkOutput($sformatf("vec%0d out_grt", i), int'(out_grt), int'(vecs[i].grt));
      checkOutput($sformatf("vec%0d out_lst", i), int'(out_lst), int'(vecs[i].lst));
      checkOutput($sformatf("vec%0d out_tag", i), int'(out_tag), int'(vecs[i].tag));
`ifdef MAG_CMP_PIPE_EQU_EN
      checkOutput($sformatf("vec%0d out_equ", i), int'(out_equ),
                  int'(~vecs[i].grt & ~vecs[i].lst));
`endif
      @(posedge clk);
      #1;
    end
    drain();

    // Back-to-back random streaming.
    popCount = 0;
    firstPop = -1;
    for (int i = 0; i < 16; i++) begin
      sendTxn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), 4'(i));
    end
    in_vld = 1'b0;
    drain();
    checkOutput("stream result count", popCount, 16);
    checkOutput("stream consecutive", lastPop - firstPop, 15);

    // Backpressure: two accepts fill the pipe, then release.
    popCount = 0;
    out_rdy  = 1'b0;
    sendTxn(1'b0, 4'h3, 4'h9, 4'd0);
    sendTxn(1'b1, 4'h3, 4'h9, 4'd1);
    in_vld = 1'b1;
    in_sgn = 1'b0;
    in_val = 4'hC;
    in_rfr = 4'hC;
    in_tag = 4'd2;
    @(negedge clk);
    checkOutput("bp in_rdy low when full", int'(in_rdy), 0);
    checkOutput("bp out_vld", int'(out_vld), 1);
    checkOutput("bp head tag", int'(out_tag), 0);
    repeat (3) @(negedge clk);
    checkOutput("bp in_rdy still low", int'(in_rdy), 0);
    @(posedge clk);
    #1 out_rdy = 1'b1;
    #1 checkOutput("bp in_rdy follows out_rdy", int'(in_rdy), 1);
    sendTxn(1'b0, 4'hC, 4'hC, 4'd2);
    sendTxn(1'b1, 4'h1, 4'hE, 4'd3);
    sendTxn(1'b0, 4'h1, 4'hE, 4'd4);
    in_vld = 1'b0;
    drain();
    checkOutput("bp result count", popCount, 5);

    // Random traffic with random backpressure and input gaps.
    randDone = 1'b0;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_vld = 1'b0;
            @(posedge clk);
            #1;
          end
          sendTxn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
        in_vld   = 1'b0;
        randDone = 1'b1;
      end
      begin
        for (int n = 0; n < 5000 && !randDone; n++) begin
          @(posedge clk);
          #1 out_rdy = 1'($urandom_range(0, 1));
        end
      end
    join
    out_rdy = 1'b1;
    drain();

    // Reset with a full pipe discards everything at once.
    out_rdy = 1'b0;
    sendTxn(1'b0, 4'hF, 4'h1, 4'd14);
    sendTxn(1'b0, 4'h1, 4'hF, 4'd15);
    in_vld = 1'b1;
    @(negedge clk);
    checkOutput("pre-reset out_vld", int'(out_vld), 1);
    #2;
    in_vld = 1'b0;
    rst_n  = 1'b0;
    #1;
    checkOutput("mid reset out_vld", int'(out_vld), 0);
    checkOutput("mid reset in_rdy", int'(in_rdy), 1);
    checkOutput("mid reset out_tag", int'(out_tag), 0);
    expQ.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n   = 1'b1;
    out_rdy = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post-reset idle", int'(out_vld), 0);
    sendTxn(1'b1, 4'h3, 4'hC, 4'd9);
    in_vld = 1'b0;
    checkOutput("post-reset early out_vld", int'(out_vld), 0);
    repeat (LEVELS - 1) @(posedge clk);
    #1;
    checkOutput("post-reset out_vld", int'(out_vld), 1);
    checkOutput("post-reset out_grt", int'(out_grt), 1);
    checkOutput("post-reset out_lst", int'(out_lst), 0);
    checkOutput("post-reset out_tag", int'(out_tag), 9);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mag_cmp_pipe.md
# mag_cmp_pipe

Pipelined, parametrised magnitude comparator with valid/ready flow control. It compares a value against a reference (unsigned or two's-complement, selected per transaction) and carries a user tag alongside. The comparison is a SPLIT-ary reduction tree with one register level per tree level. It is the streaming, timing-closed successor to the combinational `mag_cmp` and serves datapaths where the comparison width exceeds what one cycle allows.

## Interface
- `WIDTH`, default 8, operand width in bits (≥1).
- `SPLIT`, default 2, tree radix: number of groups merged per level (≥2).
- `TAG_W`, default 4, width of the pass-through user tag (≥1).
- `LEVELS`, localparam, max(1, ⌈log_SPLIT(WIDTH)⌉); this is the pipeline depth.
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `in_vld` input 1: input transaction valid.
- `in_rdy` output 1: input accepted when `in_vld & in_rdy`.
- `in_sgn` input 1: 1 = signed compare, 0 = unsigned.
- `in_val` input WIDTH: value.
- `in_rfr` input WIDTH: reference.
- `in_tag` input TAG_W: user tag.
- `out_vld` output 1: result valid.
- `out_rdy` input 1: result consumed when `out_vld & out_rdy`.
- `out_grt` output 1: value > reference.
- `out_lst` output 1: value < reference.
- `out_tag` output TAG_W: tag of the transaction.
- `out_equ` output 1: value == reference. Present only with the macro described under Configuration.

## Operation
- Signed mode: the MSB of both operands is inverted at the input, then compared unsigned. After this step the mode is not carried down the pipe.
- Operands are zero-extended on the MSB side to SPLIT^LEVELS bits. Padding bits are equal, so they never affect the result.
- Leaf compare (combinational, before stage 1): per bit, `g = v & ~r` and `l = ~v & r`.
- Each level merges SPLIT adjacent (g,l) pairs, MSB group first.
  - The first group from the MSB with g|l set decides the result.
  - If no group decides, the merged pair is g=0, l=0.
  - g and l are never both 1.
- Stage k (k=1..LEVELS) registers the level-k (g,l) vector, a valid bit and the tag. Stage LEVELS drives the outputs.
- Flow control is a bubble-collapsing pipeline.
  - `rdy[k] = ~vld[k] | rdy[k+1]`, with `rdy[LEVELS+1] = out_rdy`.
  - `in_rdy = rdy[1]`.
  - A stage loads when its own `rdy` is high. Its `vld` becomes the upstream valid.
- No transaction is dropped, duplicated or reordered.

## Timing
- Reset (asynchronous assert, synchronous-release-safe): all `vld` = 0 and all data/tag registers = 0.
  - Resulting outputs: `out_vld`=0, `out_grt`=0, `out_lst`=0, `out_equ`=0, `out_tag`=0, `in_rdy`=1.
- Latency: a transaction accepted at edge n appears at `out_vld` after edge n+LEVELS-1, provided no stall occurs. That is, LEVELS cycles from the accepting edge to the output.
- Throughput: 1 transaction/cycle while `out_rdy`=1.
- Stall with `out_rdy`=0:
  - The pipe fills to LEVELS entries.
  - `in_rdy` falls combinationally once all stages are valid.
  - Output data stays stable while `out_vld & ~out_rdy`.
- Simultaneous accept and consume on a full pipe is legal. Every stage advances on that edge.
- Bubbles: an empty stage accepts data even while downstream is stalled.
- `in_rdy` depends combinationally on `out_rdy`, through a chain of LEVELS gates. No other comb path runs from input to output.
- Reset mid-operation: all in-flight transactions are discarded immediately and no partial result is emitted.
- WIDTH=1: LEVELS=1. The single stage registers the leaf compare.

## Configuration
- `MAG_CMP_PIPE_EQU_EN` defined: the `out_equ` port exists and is registered alongside the result as `~g & ~l` from the final level. It resets to 0 and is valid only with `out_vld`.
- Undefined: no `out_equ` port and no extra logic. Equality is implied by `out_vld & ~out_grt & ~out_lst`.

## Structure
- Package `mag_cmp_pkg` holds:
  - the (g,l) pair typedef `cmp_t` (packed struct `{grt, lst}`);
  - a function `cmp_merge` that reduces an array of `cmp_t`, MSB-first;
  - a constant function computing LEVELS from WIDTH/SPLIT.
- The natural sub-module is `mag_cmp_stage`: one tree level plus its valid/tag register and ready logic. It is instantiated LEVELS times in a generate loop.

## Test plan
- Reset: hold `rst_n`=0 → `out_vld`=0, `out_grt`=`out_lst`=0, `in_rdy`=1. Release with no input → outputs unchanged.
- Unsigned, WIDTH=4, SPLIT=2: val=4'hA, rfr=4'h5, sgn=0, tag=3 → after 2 cycles `out_vld`=1, grt=1, lst=0, tag=3. Then val=rfr=4'h7 → grt=0, lst=0, equ=1 (with macro).
- Signed: val=4'hA (−6), rfr=4'h5, sgn=1 → lst=1, grt=0. Then val=4'h8, rfr=4'hF, sgn=1 → lst=1.
- Streaming: 16 random back-to-back transactions with `out_rdy`=1 → 16 results on consecutive cycles, each matching the `>`/`<` model, tags 0..15 in order.
- Backpressure: `out_rdy`=0 while driving 5 transactions → `in_rdy` falls after 2 accepts. Raise `out_rdy` → all 5 emerge in order with no loss or duplication, and output holds stable during the stall.
- Reset mid-stream with a full pipe → `out_vld`=0 at once. The first post-reset transaction emerges after LEVELS cycles with correct data.
